axis_pkt_gen: RTL and testbench

Byte-wide AXI-Stream packet transmitter. It sources frames for stream sinks and register slices in the datapath. On a start command it latches a length and seed, then emits `pkt_len` beats of incrementing data ending in `tlast`, honouring `tready` backpressure. An optional inter-packet gap follows each frame, and a completed-packet counter is kept for bring-up and test.

---
 rtl/axis_pkt_gen.sv | 167 ++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// -----------------------------------------------------------------------------
// axis_pkt_gen
//
// Byte-wide AXI-Stream packet transmitter. A start command in IDLE latches a
// beat count and a seed byte, then the block emits pkt_len beats of
// incrementing data (seed, seed+1, ... mod 256) with tlast on the final beat.
// Downstream backpressure via output_tready is honoured. After each packet an
// optional gap of GAP_CYCLES idle cycles is inserted before IDLE is re-entered,
// and a 16-bit completed-packet counter is maintained.
//
// Parameters
//   GAP_CYCLES     idle cycles inserted after each packet (0 = none)
//
// Ports
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          packet request, sampled only in IDLE
//   pkt_len[7:0]   beats per packet (1..255), latched on accepted start
//   seed[7:0]      first data byte, latched on accepted start
//   output_tdata   stream data
//   output_tvalid  stream valid
//   output_tlast   final beat marker
//   output_tready  downstream ready
//   busy           high while in SEND or GAP
//   done           one-cycle pulse after the tlast beat is accepted
//   pkt_count      completed packets, wraps 0xFFFF -> 0
//   dbg_state_o    current FSM state (0 = IDLE, 1 = SEND, 2 = GAP)
//
// Handshake: a beat transfers on any rising edge where output_tvalid and
// output_tready are both high. output_tvalid is a register and never depends
// combinationally on output_tready; once raised, tvalid/tdata/tlast hold
// stable until the beat transfers.
// -----------------------------------------------------------------------------
module axis_pkt_gen #(
    parameter int GAP_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  pkt_len,
    input  logic [7:0]  seed,
    output logic [7:0]  output_tdata,
    output logic        output_tvalid,
    output logic        output_tlast,
    input  logic        output_tready,
    output logic        busy,
    output logic        done,
    output logic [15:0] pkt_count,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Terminal value of the gap counter; only meaningful when GAP_CYCLES > 0.
    localparam logic [15:0] GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;
    localparam bit          HAS_GAP  = (GAP_CYCLES > 0);

    state_e      state_q;
    logic [7:0]  len_q;
    logic [7:0]  seed_q;
    logic [7:0]  beat_q;
    logic [15:0] gap_q;
    logic [7:0]  tdata_q;
    logic        tvalid_q;
    logic        tlast_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] pkt_count_q;

    logic        handshake;
    logic [7:0]  beat_d;

    assign handshake = tvalid_q & output_tready;
    assign beat_d    = beat_q + 8'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            len_q       <= 8'd0;
            seed_q      <= 8'd0;
            beat_q      <= 8'd0;
            gap_q       <= 16'd0;
            tdata_q     <= 8'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pkt_count_q <= 16'd0;
        end else begin
            // done is a single-cycle pulse; only the tlast handshake re-arms it.
            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // A zero-length request is dropped without any side effect.
                    if (start && (pkt_len != 8'd0)) begin
                        len_q    <= pkt_len;
                        seed_q   <= seed;
                        beat_q   <= 8'd0;
                        tdata_q  <= seed;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (pkt_len == 8'd1);
                        busy_q   <= 1'b1;
                        state_q  <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (handshake) begin
                        if (tlast_q) begin
                            tvalid_q    <= 1'b0;
                            tlast_q     <= 1'b0;
                            tdata_q     <= 8'd0;
                            beat_q      <= 8'd0;
                            done_q      <= 1'b1;
                            pkt_count_q <= pkt_count_q + 16'd1;
                            if (HAS_GAP) begin
                                gap_q   <= 16'd0;
                                state_q <= ST_GAP;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            // Advance to the next beat; data wraps naturally mod 256.
                            beat_q  <= beat_d;
                            tdata_q <= seed_q + beat_d;
                            tlast_q <= (beat_d == (len_q - 8'd1));
                        end
                    end
                end

                ST_GAP: begin
                    // GAP_CYCLES cycles here plus the mandatory IDLE cycle give
                    // GAP_CYCLES+1 cycles of tvalid low between packets.
                    if (gap_q == GAP_LAST) begin
                        gap_q   <= 16'd0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end

                default: begin
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign output_tdata  = tdata_q;
    assign output_tvalid = tvalid_q;
    assign output_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_count     = pkt_count_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_pkt_gen
//
// Directed bench for axis_pkt_gen. Two instances share clock and reset:
// dut0 with GAP_CYCLES=0 carries most scenarios, dut3 with GAP_CYCLES=3
// covers the inter-packet gap. Inputs are driven and outputs sampled on the
// falling clock edge so every observation is half a period away from the
// active edge.
// -----------------------------------------------------------------------------
module tb_axis_pkt_gen;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- dut0 (no gap) ----------------
    logic        start0;
    logic [7:0]  len0;
    logic [7:0]  seed0;
    logic        tready0;
    logic [7:0]  tdata0;
    logic        tvalid0;
    logic        tlast0;
    logic        busy0;
    logic        done0;
    logic [15:0] count0;
    logic [1:0]  dbg0;

    axis_pkt_gen #(.GAP_CYCLES(0)) dut0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start0),
        .pkt_len       (len0),
        .seed          (seed0),
        .output_tdata  (tdata0),
        .output_tvalid (tvalid0),
        .output_tlast  (tlast0),
        .output_tready (tready0),
        .busy          (busy0),
        .done          (done0),
        .pkt_count     (count0),
        .dbg_state_o   (dbg0)
    );

    // ---------------- dut3 (3-cycle gap) ----------------
    logic        start3;
    logic [7:0]  len3;
    logic [7:0]  seed3;
    logic        tready3;
    logic [7:0]  tdata3;
    logic        tvalid3;
    logic        tlast3;
    logic        busy3;
    logic        done3;
    logic [15:0] count3;
    logic [1:0]  dbg3;

    axis_pkt_gen #(.GAP_CYCLES(3)) dut3 (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start3),
        .pkt_len       (len3),
        .seed          (seed3),
        .output_tdata  (tdata3),
        .output_tvalid (tvalid3),
        .output_tlast  (tlast3),
        .output_tready (tready3),
        .busy          (busy3),
        .done          (done3),
        .pkt_count     (count3),
        .dbg_state_o   (dbg3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        start0 = 1'b0; len0 = 8'd0; seed0 = 8'd0; tready0 = 1'b1;
        start3 = 1'b0; len3 = 8'd0; seed3 = 8'd0; tready3 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b exp 0", tvalid0); end
        n_checks++; if (tdata0 !== 8'h00) begin n_fail++; $display("FAIL reset_tdata got %h exp 00", tdata0); end
        n_checks++; if (tlast0 !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b exp 0", tlast0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done0); end
        n_checks++; if (count0 !== 16'h0000) begin n_fail++; $display("FAIL reset_count got %h exp 0000", count0); end
        n_checks++; if (dbg0 !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", dbg0); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL post_reset_tvalid got %b exp 0", tvalid0); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_d [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd4; seed0 = 8'h10; tready0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (tvalid0 !== 1'b1) begin n_fail++; $display("FAIL basic_tvalid beat %0d got %b exp 1", i, tvalid0); end
            n_checks++; if (tdata0 !== exp_d[i]) begin n_fail++; $display("FAIL basic_tdata beat %0d got %h exp %h", i, tdata0, exp_d[i]); end
            n_checks++; if (tlast0 !== (i == 3)) begin n_fail++; $display("FAIL basic_tlast beat %0d got %b exp %b", i, tlast0, (i == 3)); end
            n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL basic_busy beat %0d got %b exp 1", i, busy0); end
            n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL basic_early_done beat %0d got %b exp 0", i, done0); end
            @(negedge clk);
        end
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", done0); end
        n_checks++; if (count0 !== 16'd1) begin n_fail++; $display("FAIL basic_count got %0d exp 1", count0); end
        n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL basic_tvalid_after got %b exp 0", tvalid0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b exp 0", busy0); end
        @(negedge clk);
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b exp 0", done0); end
    endtask

    task automatic test_backpressure();
        // tready per cycle, bit 0 first: 1,0,0,1,0,1
        logic [5:0] pat = 6'b101001;
        logic [7:0] exp_d [3] = '{8'hA0, 8'hA1, 8'hA2};
        int beat = 0;
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd3; seed0 = 8'hA0; tready0 = 1'b0;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tready0 = pat[c];
            n_checks++; if (tvalid0 !== 1'b1) begin n_fail++; $display("FAIL bp_tvalid cycle %0d got %b exp 1", c, tvalid0); end
            n_checks++; if (tdata0 !== exp_d[beat]) begin n_fail++; $display("FAIL bp_tdata cycle %0d got %h exp %h", c, tdata0, exp_d[beat]); end
            n_checks++; if (tlast0 !== (beat == 2)) begin n_fail++; $display("FAIL bp_tlast cycle %0d got %b exp %b", c, tlast0, (beat == 2)); end
            if (pat[c]) beat++;
            @(negedge clk);
        end
        tready0 = 1'b1;
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b exp 1", done0); end
        n_checks++; if (count0 !== 16'd2) begin n_fail++; $display("FAIL bp_count got %0d exp 2", count0); end
        n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL bp_tvalid_after got %b exp 0", tvalid0); end
    endtask

    task automatic test_wrap_single();
        logic [7:0] exp_d [3] = '{8'hFE, 8'hFF, 8'h00};
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd3; seed0 = 8'hFE;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (tdata0 !== exp_d[i]) begin n_fail++; $display("FAIL wrap_tdata beat %0d got %h exp %h", i, tdata0, exp_d[i]); end
            n_checks++; if (tlast0 !== (i == 2)) begin n_fail++; $display("FAIL wrap_tlast beat %0d got %b exp %b", i, tlast0, (i == 2)); end
            @(negedge clk);
        end
        n_checks++; if (count0 !== 16'd3) begin n_fail++; $display("FAIL wrap_count got %0d exp 3", count0); end
        // single-beat packet
        start0 = 1'b1; len0 = 8'd1; seed0 = 8'h55;
        @(negedge clk);
        start0 = 1'b0;
        n_checks++; if (tvalid0 !== 1'b1) begin n_fail++; $display("FAIL single_tvalid got %b exp 1", tvalid0); end
        n_checks++; if (tdata0 !== 8'h55) begin n_fail++; $display("FAIL single_tdata got %h exp 55", tdata0); end
        n_checks++; if (tlast0 !== 1'b1) begin n_fail++; $display("FAIL single_tlast got %b exp 1", tlast0); end
        @(negedge clk);
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL single_done got %b exp 1", done0); end
        n_checks++; if (count0 !== 16'd4) begin n_fail++; $display("FAIL single_count got %0d exp 4", count0); end
        n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL single_tvalid_after got %b exp 0", tvalid0); end
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd0; seed0 = 8'h12;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL zero_tvalid cycle %0d got %b exp 0", i, tvalid0); end
            n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL zero_busy cycle %0d got %b exp 0", i, busy0); end
            n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL zero_done cycle %0d got %b exp 0", i, done0); end
            n_checks++; if (count0 !== 16'd4) begin n_fail++; $display("FAIL zero_count cycle %0d got %0d exp 4", i, count0); end
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy();
        logic [7:0] exp_d [5] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd5; seed0 = 8'h30;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (tdata0 !== exp_d[i]) begin n_fail++; $display("FAIL busy_tdata beat %0d got %h exp %h", i, tdata0, exp_d[i]); end
            n_checks++; if (tlast0 !== (i == 4)) begin n_fail++; $display("FAIL busy_tlast beat %0d got %b exp %b", i, tlast0, (i == 4)); end
            // Changing length/seed mid-packet must not disturb this packet.
            if (i == 0) begin seed0 = 8'h99; len0 = 8'd2; end
            @(negedge clk);
        end
        n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL busy_gap_tvalid got %b exp 0", tvalid0); end
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL busy_done got %b exp 1", done0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL busy_idle got %b exp 0", busy0); end
        n_checks++; if (count0 !== 16'd5) begin n_fail++; $display("FAIL busy_count1 got %0d exp 5", count0); end
        @(negedge clk);
        // start still high: the IDLE cycle accepted a fresh packet with new values
        n_checks++; if (tvalid0 !== 1'b1) begin n_fail++; $display("FAIL b2b_tvalid got %b exp 1", tvalid0); end
        n_checks++; if (tdata0 !== 8'h99) begin n_fail++; $display("FAIL b2b_tdata0 got %h exp 99", tdata0); end
        n_checks++; if (tlast0 !== 1'b0) begin n_fail++; $display("FAIL b2b_tlast0 got %b exp 0", tlast0); end
        @(negedge clk);
        start0 = 1'b0;
        n_checks++; if (tdata0 !== 8'h9A) begin n_fail++; $display("FAIL b2b_tdata1 got %h exp 9a", tdata0); end
        n_checks++; if (tlast0 !== 1'b1) begin n_fail++; $display("FAIL b2b_tlast1 got %b exp 1", tlast0); end
        @(negedge clk);
        n_checks++; if (count0 !== 16'd6) begin n_fail++; $display("FAIL b2b_count got %0d exp 6", count0); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL b2b_no_queue cycle %0d got %b exp 0", i, tvalid0); end
        end
    endtask

    task automatic test_gap();
        // Per-cycle expectations from the first beat onward, bit 0 first.
        logic [7:0] exp_v = 8'b11000011;
        logic [7:0] exp_b = 8'b11011111;
        @(negedge clk);
        start3 = 1'b1; len3 = 8'd2; seed3 = 8'h01; tready3 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 6) start3 = 1'b0;
            n_checks++; if (tvalid3 !== exp_v[j]) begin n_fail++; $display("FAIL gap_tvalid cycle %0d got %b exp %b", j, tvalid3, exp_v[j]); end
            n_checks++; if (busy3 !== exp_b[j]) begin n_fail++; $display("FAIL gap_busy cycle %0d got %b exp %b", j, busy3, exp_b[j]); end
        end
        @(negedge clk);
        n_checks++; if (done3 !== 1'b1) begin n_fail++; $display("FAIL gap_done got %b exp 1", done3); end
        n_checks++; if (count3 !== 16'd2) begin n_fail++; $display("FAIL gap_count got %0d exp 2", count3); end
        repeat (6) @(negedge clk);
        n_checks++; if (tvalid3 !== 1'b0) begin n_fail++; $display("FAIL gap_idle_tvalid got %b exp 0", tvalid3); end
        n_checks++; if (busy3 !== 1'b0) begin n_fail++; $display("FAIL gap_idle_busy got %b exp 0", busy3); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd6; seed0 = 8'h40;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (tdata0 !== 8'h42) begin n_fail++; $display("FAIL rst_mid_tdata got %h exp 42", tdata0); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tvalid got %b exp 0", tvalid0); end
        n_checks++; if (tlast0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tlast got %b exp 0", tlast0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", busy0); end
        n_checks++; if (tdata0 !== 8'h00) begin n_fail++; $display("FAIL rst_mid_tdata0 got %h exp 00", tdata0); end
        n_checks++; if (count0 !== 16'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d exp 0", count0); end
        repeat (2) begin
            @(negedge clk);
            n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b exp 0", done0); end
        end
        reset_n = 1'b1;
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd2; seed0 = 8'h70;
        @(negedge clk);
        start0 = 1'b0;
        n_checks++; if (tdata0 !== 8'h70) begin n_fail++; $display("FAIL rst_fresh_tdata0 got %h exp 70", tdata0); end
        @(negedge clk);
        n_checks++; if (tdata0 !== 8'h71) begin n_fail++; $display("FAIL rst_fresh_tdata1 got %h exp 71", tdata0); end
        n_checks++; if (tlast0 !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_tlast got %b exp 1", tlast0); end
        @(negedge clk);
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL rst_fresh_done got %b exp 1", done0); end
        n_checks++; if (count0 !== 16'd1) begin n_fail++; $display("FAIL rst_fresh_count got %0d exp 1", count0); end
    endtask

    task automatic test_count_wrap();
        @(negedge clk);
        force dut0.pkt_count_q = 16'hFFFF;
        #1 release dut0.pkt_count_q;
        n_checks++; if (count0 !== 16'hFFFF) begin n_fail++; $display("FAIL cwrap_preload got %h exp ffff", count0); end
        @(negedge clk);
        start0 = 1'b1; len0 = 8'd1; seed0 = 8'hEE;
        @(negedge clk);
        start0 = 1'b0;
        n_checks++; if (tdata0 !== 8'hEE) begin n_fail++; $display("FAIL cwrap_tdata got %h exp ee", tdata0); end
        @(negedge clk);
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL cwrap_done got %b exp 1", done0); end
        n_checks++; if (count0 !== 16'h0000) begin n_fail++; $display("FAIL cwrap_count got %h exp 0000", count0); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_single();
        test_zero_len();
        test_start_while_busy();
        test_gap();
        test_reset_mid();
        test_count_wrap();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
